// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) serial receive path.
// Holds the codeword/data widths, parity bit positions used by the encoder
// and decoder, the frame receiver state encoding and the frame counter width.
package hamming_pkg;

   localparam int unsigned CODE_W      = 7;
   localparam int unsigned DATA_W      = 4;
   localparam int unsigned FRAME_CNT_W = 8;

   // Parity bit positions inside the codeword (bit 6 = Hamming position 1).
   localparam int unsigned P1_IDX = 6;
   localparam int unsigned P2_IDX = 5;
   localparam int unsigned P4_IDX = 3;

   // Receiver FSM encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_DATA = ST_DATA,
      S_STOP = ST_STOP
   } rx_state_e;

endpackage : hamming_pkg

// File: rtl/hamming_out_buf.sv
// One-entry valid/ready output buffer for received codewords.
// Accepts a load when empty or when the current word drains in the same
// cycle; otherwise the new word is dropped and an overrun pulse is raised.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_load          : a complete, well-framed codeword is offered
//   i_data          : offered codeword
//   i_ready         : downstream accepts the held word
//   o_data          : held codeword, stable while o_valid=1
//   o_valid         : buffer holds an unconsumed codeword
//   o_overrun       : one-cycle pulse, offered word dropped because full
//   o_frame_cnt     : number of words loaded, wraps
module hamming_out_buf
   import hamming_pkg::*;
#(
   parameter int unsigned W = 7
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_load,
   input  logic [W-1:0]           i_data,
   input  logic                   i_ready,
   output logic [W-1:0]           o_data,
   output logic                   o_valid,
   output logic                   o_overrun,
   output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

   logic [W-1:0]           r_data;
   logic                   r_valid;
   logic                   r_overrun;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   logic w_drain;
   logic w_accept;
   logic w_drop;

   // A drain in the same cycle frees the slot for the incoming word.
   assign w_drain  = r_valid & i_ready;
   assign w_accept = i_load & (~r_valid | w_drain);
   assign w_drop   = i_load & ~w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_data      <= i_data;
            r_valid     <= 1'b1;
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
         r_overrun <= w_drop;
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_overrun   = r_overrun;
   assign o_frame_cnt = r_frame_cnt;

endmodule : hamming_out_buf

// File: rtl/hamming_frame_rx.sv
// Serial frame receiver feeding the Hamming(7,4) decoder.
// Frames are start bit, CODE_W code bits (MSB first) and a stop bit, all
// sampled on bit_tick. Good frames are handed to a one-entry output buffer
// whose register drives the decoder directly.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   ser_in      : serial line, sampled only when bit_tick=1
//   bit_tick    : one-cycle strobe per bit period
//   code        : assembled codeword, bit CODE_W-1 is the first bit received
//   code_valid  : buffer holds an unconsumed codeword
//   code_ready  : downstream accepts the codeword
//   frame_err   : one-cycle pulse, stop bit not at idle level
//   overrun     : one-cycle pulse, good frame dropped because buffer full
//   frame_cnt   : count of codewords loaded into the buffer, wraps
module hamming_frame_rx
   import hamming_pkg::rx_state_e;
   import hamming_pkg::S_IDLE;
   import hamming_pkg::S_DATA;
   import hamming_pkg::S_STOP;
   import hamming_pkg::FRAME_CNT_W;
#(
   parameter int unsigned CODE_W   = hamming_pkg::CODE_W,
   parameter logic        IDLE_LVL = 1'b1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ser_in,
   input  logic                   bit_tick,
   output logic [CODE_W-1:0]      code,
   output logic                   code_valid,
   input  logic                   code_ready,
   output logic                   frame_err,
   output logic                   overrun,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

   rx_state_e          r_state;
   logic [CODE_W-1:0]  r_shift;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_frame_err;

   rx_state_e          w_state_nxt;
   logic [CODE_W-1:0]  w_shift_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_frame_err_nxt;
   logic               w_load;

   // State, shifter, bit counter and framing-error pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_cnt       <= w_cnt_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // Next-state logic; nothing advances without a bit tick.
   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_cnt_nxt       = r_cnt;
      w_frame_err_nxt = 1'b0;
      w_load          = 1'b0;
      if (bit_tick) begin
         case (r_state)
            S_IDLE: begin
               if (ser_in != IDLE_LVL) begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = '0;
               end
            end
            S_DATA: begin
               // MSB-first: the first data bit ends up in the top bit.
               w_shift_nxt = {r_shift[CODE_W-2:0], ser_in};
               if (r_cnt == CNT_W'(CODE_W - 1)) begin
                  w_state_nxt = S_STOP;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               // Stop slot never doubles as the next start bit.
               w_state_nxt = S_IDLE;
               if (ser_in == IDLE_LVL) begin
                  w_load = 1'b1;
               end else begin
                  w_frame_err_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   hamming_out_buf #(
      .W (CODE_W)
   ) u_out_buf (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_data      (r_shift),
      .i_ready     (code_ready),
      .o_data      (code),
      .o_valid     (code_valid),
      .o_overrun   (overrun),
      .o_frame_cnt (frame_cnt)
   );

   assign frame_err = r_frame_err;

endmodule : hamming_frame_rx

// File: doc/hamming_frame_rx.md
Name: hamming_frame_rx

Overview:
Serial front end for the Hamming(7,4) decoder. It receives framed serial codewords, each as one start bit, 7 code bits and one stop bit, sampled on an external bit-rate strobe. It assembles each frame into a 7-bit codeword and presents it on a one-entry valid/ready output buffer. The buffer feeds the combinational decoder directly. The block also flags framing errors and overruns.

Parameters:
CODE_W, 7, codeword width; fixed at 7 for the Hamming(7,4) path, but the bit counter is sized from it.
IDLE_LVL, 1, idle/stop line level; start bit is the inverse.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ser_in  input  1  serial line, sampled only when bit_tick=1
bit_tick  input  1  one-cycle strobe per bit period, already centred in the bit
code  output  CODE_W  assembled codeword; bit 6 = Hamming position 1
code_valid  output  1  buffer holds an unconsumed codeword
code_ready  input  1  downstream accepts; transfer when code_valid & code_ready
frame_err  output  1  one-cycle pulse: stop bit sampled != IDLE_LVL
overrun  output  1  one-cycle pulse: completed frame dropped because buffer full
frame_cnt  output  8  count of codewords loaded into buffer, wraps 255->0

Behaviour:
- Reset, asynchronous: FSM=IDLE, shift reg=0, bit counter=0, code=0, code_valid=0, frame_err=0, overrun=0, frame_cnt=0. Reset mid-frame discards the partial frame.
- All FSM and shift actions occur only in cycles with bit_tick=1. Otherwise state holds, except the output handshake and the pulse clears.
- IDLE: on tick with ser_in=!IDLE_LVL (start bit), go to DATA with counter=0. A tick with ser_in=IDLE_LVL stays in IDLE.
- DATA: on each tick, shift ser_in into the LSB (shift left). The first received bit ends in code[6]. The counter increments; after the CODE_W-th bit go to STOP.
- STOP, on tick:
  - ser_in=IDLE_LVL: frame good.
    - Buffer empty, or draining in the same cycle (code_valid & code_ready): load code, set code_valid=1, frame_cnt+1.
    - Otherwise: drop the frame, pulse overrun; the buffer keeps the old word.
  - ser_in!=IDLE_LVL: pulse frame_err, no load.
  - In all cases go to IDLE. No back-to-back start in the stop slot: the next start is detected on a following tick.
- Output buffer:
  - code is stable while code_valid=1.
  - code_valid clears the cycle after a transfer, unless a load occurs in that same cycle. Simultaneous drain and load leaves code_valid=1 with the new word and no overrun.
  - code_ready while code_valid=0 has no effect.
- Latency: code_valid rises on the clk edge of the stop-bit tick, 1 cycle after the tick is sampled.
- frame_err and overrun are registered pulses, high for exactly one clk cycle. They are mutually exclusive per frame.
- bit_tick held high continuously is legal: one bit per clk cycle, 9 cycles per frame.

Decomposition:
- Shared package hamming_pkg:
  - CODE_W=7, DATA_W=4.
  - FSM state enum {IDLE, DATA, STOP} as 2-bit localparams.
  - Parity-position constants P1_IDX=6, P2_IDX=5, P4_IDX=3, shared with the encoder and decoder.
- Natural sub-module: hamming_out_buf, the one-entry valid/ready register with load, drain and overrun logic. The FSM and shifter stay in the top module.
- Integration: code drives the decoder input directly, with no extra register.

Test Plan:
- Tick every cycle; send start, 1011010, stop=1 -> code=7'b1011010, code_valid=1 on the stop tick's edge, frame_cnt=1, no error pulses.
- Frame with stop bit 0 -> frame_err pulses for 1 cycle, code_valid stays 0, frame_cnt unchanged, next good frame 0110011 is accepted.
- code_ready=0; send frames 1010101 then 0001111 -> code holds 1010101, overrun pulses once at the second stop, frame_cnt=1.
- code_ready asserted exactly on the second frame's stop-tick cycle -> 0001111 loaded, code_valid stays 1, no overrun, frame_cnt=2.
- bit_tick every 4th cycle with ser_in toggling between ticks -> only tick-sampled values appear in code; glitch-low between ticks in IDLE causes no start.
- Assert rst after 4 data bits, release, send full frame 1100001 -> outputs 0 during reset, then code=1100001 with frame_cnt=1.
